// File: rtl/class_argmax.sv
// Streaming argmax over an N_CLASS logit burst: tracks top-1/top-2 on the fly and
// publishes class index, score and top-1/top-2 margin when the burst ends.
module class_argmax #(
  parameter int N_CLASS = 11,
  parameter int DW      = 16,
  parameter int IDXW    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   din,
  input  logic            din_vld,
  output logic [IDXW-1:0] class_idx,
  output logic [DW-1:0]   class_score,
  output logic [DW:0]     margin,
  output logic            result_vld,
  output logic            frame_err,
  output logic [15:0]     frame_cnt
);

  typedef enum logic [1:0] {WAIT_LOW, IDLE, ACC} state_t;

  localparam logic [IDXW-1:0]   CNT_FULL = IDXW'(N_CLASS);
  localparam logic [IDXW-1:0]   CNT_MAX  = '1;
  localparam logic [DW-1:0]     MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  state_t                 state;
  logic [IDXW-1:0]        cnt;
  logic signed [DW-1:0]   best;
  logic signed [DW-1:0]   second;
  logic [IDXW-1:0]        best_idx;

  logic signed [DW-1:0]   din_s;
  logic signed [DW:0]     diff;

  assign din_s = din;
  // best >= second always holds, so the sign-extended difference is non-negative
  assign diff  = {best[DW-1], best} - {second[DW-1], second};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_LOW;
      cnt         <= '0;
      best        <= '0;
      second      <= '0;
      best_idx    <= '0;
      class_idx   <= '0;
      class_score <= '0;
      margin      <= '0;
      result_vld  <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      result_vld <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        WAIT_LOW: begin
          // a burst already running when reset lifted must not be classified
          if (!din_vld) state <= IDLE;
        end
        IDLE: begin
          if (din_vld) begin
            state    <= ACC;
            best     <= din_s;
            best_idx <= '0;
            second   <= MOST_NEG;
            cnt      <= IDXW'(1);
          end
        end
        ACC: begin
          if (din_vld) begin
            if (cnt < CNT_FULL) begin
              // strict compares keep the lower index on ties
              if (din_s > best) begin
                second   <= best;
                best     <= din_s;
                best_idx <= cnt;
              end else if (din_s > second) begin
                second <= din_s;
              end
            end
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end else begin
            state <= IDLE;
            if (cnt == CNT_FULL) begin
              class_idx   <= best_idx;
              class_score <= best;
              margin      <= diff;
              result_vld  <= 1'b1;
              frame_cnt   <= frame_cnt + 16'd1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_class_argmax.sv
// Bench for class_argmax: per-cycle comparison against a frame-level reference model
// that buffers each burst and picks top-1/top-2 by plain search when it ends.
module tb_class_argmax;

  typedef struct packed {
    logic        rv;
    logic        fe;
    logic [3:0]  idx;
    logic [15:0] score;
    logic [16:0] mrg;
    logic [15:0] fcnt;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_vld = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  class_idx;
  logic [15:0] class_score;
  logic [16:0] margin;
  logic        result_vld;
  logic        frame_err;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  snap_t obs, expv, m_exp;
  bit m_wait;
  logic signed [15:0] m_run[$];
  logic [15:0] fr[$];
  logic [15:0] pool [4];

  always #5 clk = ~clk;

  class_argmax dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .class_idx(class_idx), .class_score(class_score), .margin(margin),
    .result_vld(result_vld), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  // One cycle: sample outputs and current expectation, drive inputs, advance the model.
  task automatic step(input logic r, input logic v, input logic [15:0] d);
    int bi;
    logic signed [15:0] b, s;
    @(negedge clk);
    obs  = {result_vld, frame_err, class_idx, class_score, margin, frame_cnt};
    expv = m_exp;
    rst_n = r; din_vld = v; din = d;
    cyc++;
    m_exp.rv = 1'b0;
    m_exp.fe = 1'b0;
    if (!r) begin
      m_wait = 1'b1;
      m_run.delete();
      m_exp = '0;
    end else if (m_wait) begin
      if (!v) m_wait = 1'b0;
    end else if (v) begin
      m_run.push_back(d);
    end else if (m_run.size() > 0) begin
      if (m_run.size() == 11) begin
        bi = 0;
        for (int j = 1; j < 11; j++) if (m_run[j] > m_run[bi]) bi = j;
        b = m_run[bi];
        s = 16'sh8000;
        for (int j = 0; j < 11; j++) if (j != bi && m_run[j] > s) s = m_run[j];
        m_exp.idx   = 4'(bi);
        m_exp.score = b;
        m_exp.mrg   = {b[15], b} - {s[15], s};
        m_exp.fcnt  = m_exp.fcnt + 16'd1;
        m_exp.rv    = 1'b1;
      end else begin
        m_exp.fe = 1'b1;
      end
      m_run.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({class_idx, class_score, margin, result_vld, frame_err, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_values got idx=%0d score=%h margin=%h rv=%b fe=%b cnt=%0d want all 0",
               class_idx, class_score, margin, result_vld, frame_err, frame_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, obs, expv); end
    end
  endtask

  task automatic test_nominal();
    snap_t got = '0;
    int npulse = 0, at = -1;
    fr.delete();
    for (int i = 0; i < 11; i++) fr.push_back(16'((i + 1) * 256));
    fr[7] = 16'h1000;
    for (int i = 0; i < 14; i++) begin
      if (i < 11) step(1'b1, 1'b1, fr[i]); else step(1'b1, 1'b0, 16'h0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL nominal cyc=%0d got=%h want=%h", cyc, obs, expv); end
      if (obs.rv) begin got = obs; npulse++; at = i; end
    end
    checks++;
    if (npulse != 1 || at != 12 || {got.idx, got.score, got.mrg, got.fcnt} !== {4'd7, 16'h1000, 17'h00500, 16'd1}) begin
      errors++;
      $display("FAIL nominal_result got pulses=%0d at=%0d idx=%0d score=%h margin=%h cnt=%0d want 1 at 12 idx=7 score=1000 margin=00500 cnt=1",
               npulse, at, got.idx, got.score, got.mrg, got.fcnt);
    end
  endtask

  task automatic test_ties();
    snap_t got = '0;
    int npulse = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 11) step(1'b1, 1'b1, (i == 3 || i == 9) ? 16'hFC00 : 16'hF000);
      else step(1'b1, 1'b0, 16'h0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL ties cyc=%0d got=%h want=%h", cyc, obs, expv); end
      if (obs.rv) begin got = obs; npulse++; end
    end
    checks++;
    if (npulse != 1 || {got.idx, got.score, got.mrg, got.fcnt} !== {4'd3, 16'hFC00, 17'h0, 16'd2}) begin
      errors++;
      $display("FAIL ties_result got pulses=%0d idx=%0d score=%h margin=%h cnt=%0d want 1 idx=3 score=fc00 margin=0 cnt=2",
               npulse, got.idx, got.score, got.mrg, got.fcnt);
    end
  endtask

  task automatic test_len_err();
    int nerr = 0, nres = 0;
    fr.delete();
    for (int i = 0; i < 10; i++) fr.push_back(16'($urandom));
    fr.push_back(16'h0000);
    for (int i = 0; i < 12; i++) fr.push_back(16'($urandom));
    fr.push_back(16'h0000);
    // the two zero entries above mark the low cycles
    for (int i = 0; i < fr.size() + 2; i++) begin
      if (i == 10 || i == 23 || i >= fr.size()) step(1'b1, 1'b0, 16'h0);
      else step(1'b1, 1'b1, fr[i]);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL len_err cyc=%0d got=%h want=%h", cyc, obs, expv); end
      if (obs.fe) nerr++;
      if (obs.rv) nres++;
    end
    checks++;
    if (nerr != 2 || nres != 0 || {class_idx, class_score, margin, frame_cnt} !== {4'd3, 16'hFC00, 17'h0, 16'd2}) begin
      errors++;
      $display("FAIL len_err_hold got errs=%0d results=%0d idx=%0d score=%h margin=%h cnt=%0d want errs=2 results=0 idx=3 score=fc00 margin=0 cnt=2",
               nerr, nres, class_idx, class_score, margin, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    snap_t p[$];
    int at[$];
    logic [15:0] v;
    logic [15:0] base;
    base = m_exp.fcnt;
    fr.delete();
    fr.push_back(16'h7FFF);
    for (int i = 1; i < 11; i++) fr.push_back(16'h8000);
    for (int i = 0; i < 10; i++) begin
      v = 16'($urandom);
      if (v == 16'h7FFF) v = 16'h0;
      fr.push_back(v);
    end
    fr.push_back(16'h7FFF);
    for (int i = 0; i < 26; i++) begin
      if (i < 11) step(1'b1, 1'b1, fr[i]);
      else if (i >= 12 && i < 23) step(1'b1, 1'b1, fr[i - 1]);
      else step(1'b1, 1'b0, 16'h0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, obs, expv); end
      if (obs.rv) begin p.push_back(obs); at.push_back(i); end
    end
    checks++;
    if (p.size() != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d pulses want 2", p.size());
    end else begin
      checks++;
      if (at[0] != 12 || at[1] != 24 || {p[0].idx, p[0].mrg, p[0].fcnt, p[1].idx, p[1].fcnt} !==
          {4'd0, 17'h0FFFF, base + 16'd1, 4'd10, base + 16'd2}) begin
        errors++;
        $display("FAIL b2b_result got at=%0d,%0d idx=%0d,%0d margin0=%h cnt=%0d,%0d want at=12,24 idx=0,10 margin0=0ffff cnt=%0d,%0d",
                 at[0], at[1], p[0].idx, p[1].idx, p[0].mrg, p[0].fcnt, p[1].fcnt, base + 16'd1, base + 16'd2);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nres = 0, nerr = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 16'($urandom));
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL rst_mid cyc=%0d got=%h want=%h", cyc, obs, expv); end
    end
    step(1'b0, 1'b1, 16'h7000);
    #1;
    checks++;
    if ({class_idx, class_score, margin, result_vld, frame_err, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_async got idx=%0d score=%h margin=%h rv=%b fe=%b cnt=%0d want all 0",
               class_idx, class_score, margin, result_vld, frame_err, frame_cnt);
    end
    for (int i = 0; i < 22; i++) begin
      if (i < 2) step(1'b0, 1'b1, 16'($urandom));
      else if (i < 6) step(1'b1, 1'b1, 16'($urandom));
      else if (i == 6 || i >= 18) step(1'b1, 1'b0, 16'h0);
      else step(1'b1, 1'b1, 16'($urandom));
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL rst_release cyc=%0d got=%h want=%h", cyc, obs, expv); end
      if (obs.rv) nres++;
      if (obs.fe) nerr++;
    end
    checks++;
    if (nres != 1 || nerr != 0 || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL rst_release_result got results=%0d errs=%0d cnt=%0d want 1 0 1", nres, nerr, frame_cnt);
    end
  endtask

  task automatic test_wrap();
    snap_t got = '0;
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    m_exp.fcnt = 16'hFFFF;
    for (int i = 0; i < 14; i++) begin
      if (i < 11) step(1'b1, 1'b1, 16'($urandom)); else step(1'b1, 1'b0, 16'h0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL wrap cyc=%0d got=%h want=%h", cyc, obs, expv); end
      if (obs.rv) got = obs;
    end
    checks++;
    if (got.rv !== 1'b1 || got.fcnt !== 16'd0) begin
      errors++;
      $display("FAIL wrap_cnt got rv=%b cnt=%0d want rv=1 cnt=0", got.rv, got.fcnt);
    end
  endtask

  task automatic test_random();
    int len, gap, mode;
    logic [15:0] v;
    for (int f = 0; f < 40; f++) begin
      len  = ($urandom_range(0, 9) < 7) ? 11 : int'($urandom_range(1, 17));
      gap  = $urandom_range(1, 3);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < len + gap; i++) begin
        if (mode == 1) v = pool[$urandom_range(0, 3)];
        else if (mode == 2) v = 16'($urandom_range(0, 15) << 8);
        else v = 16'($urandom);
        step(1'b1, (i < len) ? 1'b1 : 1'b0, v);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL random frame=%0d cyc=%0d got=%h want=%h", f, cyc, obs, expv); end
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 16'h0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL random_tail cyc=%0d got=%h want=%h", cyc, obs, expv); end
    end
  endtask

  initial begin
    m_exp  = '0;
    m_wait = 1'b1;
    pool[0] = 16'h8000; pool[1] = 16'h7FFF; pool[2] = 16'h0000; pool[3] = 16'hFC00;
    test_reset();
    test_nominal();
    test_ties();
    test_len_err();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
